fifo_rr_arbiter: RTL and testbench
==================================

# fifo_rr_arbiter

Round-robin write arbiter and flow controller for a `shift_register_fifo` instance. It shares the FIFO's single push port among NREQ requesters with fair rotating priority. It drives `push`/`pop` so the FIFO never overflows or underflows, since the FIFO itself has no protection against either. It exposes the FIFO read side as a valid/ready stream and keeps a shadow occupancy count that cross-checks the FIFO's `empty`/`full` flags.

## Interface
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, data width; must match the FIFO WIDTH
- DEPTH, 8, FIFO depth; must match the FIFO DEPTH
- CNTWID, $clog2(DEPTH+1), occupancy width
- IDXWID, $clog2(NREQ), requester index width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester write request
- req_data  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant; the grant cycle is the transfer cycle
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  WIDTH  FIFO head data
- fifo_push  out  1  to FIFO push
- fifo_pop  out  1  to FIFO pop
- fifo_data_in  out  WIDTH  to FIFO data_in
- fifo_empty  in  1  from FIFO empty
- fifo_full  in  1  from FIFO full
- fifo_data_out  in  WIDTH  from FIFO data_out
- occupancy  out  CNTWID  shadow entry count
- err  out  1  sticky flag-mismatch error

## Operation
- Read side (combinational):
  - out_valid = !fifo_empty
  - fifo_pop = out_valid & out_ready
  - out_data = fifo_data_out
- Space: space = !fifo_full | fifo_pop. A push into a full FIFO is allowed only when a pop happens in the same cycle.
- Arbitration (combinational):
  - Search starts at index ptr, ascends, wraps past NREQ-1 to 0.
  - The first i with req[i]=1 gets gnt[i]=1, but only if space=1. Otherwise gnt=0.
  - gnt is at most one-hot. A requester that has req=1 and gnt=0 keeps req and req_data stable until granted.
- fifo_push = |gnt. fifo_data_in = req_data of the granted index, or 0 when there is no grant.
- Pointer register ptr (IDXWID bits, reset 0):
  - After a push by index g, ptr <= g+1, or 0 when g = NREQ-1.
  - Otherwise ptr holds.
  - When NREQ is not a power of two, ptr never takes a value ≥ NREQ.
- Shadow occupancy (reset 0): occupancy <= occupancy + fifo_push - fifo_pop, in CNTWID-bit arithmetic. It stays within 0..DEPTH by construction.
- Error checker:
  - err sets when, out of reset, (occupancy==0) != fifo_empty or (occupancy==DEPTH) != fifo_full.
  - err is sticky and is cleared only by rst.
  - It is checked every cycle in which rst=0, using the registered occupancy.

## Timing
- Reset values: ptr=0, occupancy=0, err=0.
  - With the FIFO also in reset (empty): gnt=0 is forced during rst, so fifo_push=0.
  - out_valid=0, fifo_pop=0.
- gnt, fifo_push, fifo_data_in and fifo_pop are same-cycle combinational. The FIFO captures on the same posedge. Zero-cycle arbitration latency.
- Write-to-read latency: an entry pushed at edge N into an empty FIFO gives out_valid=1 in cycle N+1, with out_data equal to that entry.
- Simultaneous push and pop:
  - Non-empty FIFO: occupancy is unchanged.
  - Full FIFO with out_ready=1: push is permitted and the count stays DEPTH.
- Full with out_ready=0: gnt=0 for all requesters and ptr holds. No overflow is possible.
- Empty: fifo_pop=0 regardless of out_ready. No underflow is possible.
- rst asserted mid-operation: on the next edge ptr, occupancy and err clear. gnt is forced to 0 while rst=1.
- Throughput: one push per cycle, and one pop per cycle.
- Fairness: with all requesters continuously asserting req and space available, grants rotate 0,1,…,NREQ-1,0. Each requester waits at most NREQ-1 grants.

## Test plan
- Reset, then req=4'b1111 with distinct data A,B,C,D, out_ready=0.
  - Grants go to 0,1,2,3,0,1,2,3 over 8 cycles.
  - Then full=1, gnt=0, occupancy=8, err=0.
- Full FIFO, req[2]=1, out_ready=1 for one cycle.
  - gnt=4'b0100, push and pop in the same cycle, occupancy stays 8, out_data advances to the second entry.
- ptr=3, only req[1]=1 → gnt=4'b0010, next ptr=2. Then req=4'b1111 → gnt=4'b0100.
- Drain with out_ready=1 and req=0.
  - Data emerges in push order A,B,C,D,A,B,C,D.
  - out_valid=0 after the 8th pop, and fifo_pop=0 on the empty FIFO.
- Force fifo_empty=0 while occupancy=0 → err=1 on the next cycle. err stays 1 until rst.
- Assert rst mid-stream with occupancy=5 → next cycle occupancy=0, ptr=0, err=0, gnt=0.

Source files
------------

// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if
// Requester-side and consumer-side handshake bundle for fifo_rr_arbiter.
//   req       : per-requester write request (NREQ bits)
//   req_data  : packed requester data, requester i at [i*WIDTH +: WIDTH]
//   gnt       : one-hot grant; a grant is the transfer
//   out_valid : FIFO head is valid
//   out_ready : consumer accepts the head
//   out_data  : FIFO head data
// master = requesters/consumer side, slave = arbiter side.
interface fifo_rr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;

  modport master (
    output req, req_data, out_ready,
    input  gnt, out_valid, out_data
  );

  modport slave (
    input  req, req_data, out_ready,
    output gnt, out_valid, out_data
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
// Round-robin write arbiter and flow controller in front of a
// shift_register_fifo. Shares the FIFO push port among NREQ requesters,
// never pushes into a full FIFO unless it pops in the same cycle, never
// pops an empty FIFO, and keeps a shadow occupancy count that is
// cross-checked against the FIFO's empty/full flags.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : requester req/req_data/gnt and output valid/ready stream
//   fifo_push     : push strobe to the FIFO
//   fifo_pop      : pop strobe to the FIFO
//   fifo_data_in  : write data to the FIFO
//   fifo_empty    : FIFO empty flag
//   fifo_full     : FIFO full flag
//   fifo_data_out : FIFO head data
//   occupancy     : shadow entry count
//   err           : sticky flag-mismatch error
module fifo_rr_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int CNTWID = $clog2(DEPTH + 1),
  parameter int IDXWID = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  fifo_rr_arbiter_if.slave    bus,
  output logic                fifo_push,
  output logic                fifo_pop,
  output logic [WIDTH-1:0]    fifo_data_in,
  input  logic                fifo_empty,
  input  logic                fifo_full,
  input  logic [WIDTH-1:0]    fifo_data_out,
  output logic [CNTWID-1:0]   occupancy,
  output logic                err
);

  logic [IDXWID-1:0] ptr_q, ptr_d;
  logic [CNTWID-1:0] occ_q, occ_d;
  logic              err_q, err_d;

  logic              space;
  logic              grant_found;
  logic [IDXWID-1:0] grant_idx;
  logic [NREQ-1:0]   gnt_c;
  logic [WIDTH-1:0]  push_data;
  int                idx;

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_data_out;
  assign fifo_pop      = !fifo_empty && bus.out_ready;

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign space = !fifo_full || fifo_pop;

  // Search for the first requester starting at ptr and wrapping; the grant is
  // suppressed in reset and when there is no room.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    gnt_c       = '0;
    push_data   = '0;
    idx         = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && bus.req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDXWID'(idx);
      end
    end
    if (grant_found && space && !rst) begin
      gnt_c[grant_idx] = 1'b1;
      push_data        = bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];
    end
  end

  assign bus.gnt      = gnt_c;
  assign fifo_push    = |gnt_c;
  assign fifo_data_in = push_data;

  // Next-state for pointer, shadow count and sticky error. The pointer moves
  // one past the granted index so the last winner becomes lowest priority;
  // the explicit wrap keeps it below NREQ when NREQ is not a power of two.
  always_comb begin
    ptr_d = ptr_q;
    if (fifo_push) begin
      if (int'(grant_idx) == NREQ - 1) ptr_d = '0;
      else                            ptr_d = grant_idx + 1'b1;
    end
    occ_d = occ_q + CNTWID'(fifo_push) - CNTWID'(fifo_pop);
    err_d = err_q
          | ((occ_q == '0) != fifo_empty)
          | ((occ_q == CNTWID'(DEPTH)) != fifo_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  assign occupancy = occ_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter
// Self-checking bench for fifo_rr_arbiter. A behavioural FIFO stands in for
// shift_register_fifo; a round-robin reference model predicts grants, and a
// scoreboard queue holds pushed data until it is popped from the FIFO head.
module tb_fifo_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_push, fifo_pop;
  logic [WIDTH-1:0] fifo_data_in;
  logic fifo_empty, fifo_full;
  logic [WIDTH-1:0] fifo_data_out;
  logic [3:0] occupancy;
  logic err;

  fifo_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  fifo_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .fifo_push     (fifo_push),
    .fifo_pop      (fifo_pop),
    .fifo_data_in  (fifo_data_in),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_data_out (fifo_data_out),
    .occupancy     (occupancy),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO; flags come from registered copies so they change only
  // after the edge, like the real FIFO.
  logic [WIDTH-1:0] fq[$];
  int               fifoCount = 0;
  logic [WIDTH-1:0] fifoHead  = '0;
  logic             forceNotEmpty = 1'b0;

  always @(posedge clk) begin
    if (rst) fq.delete();
    else begin
      if (fifo_pop && fq.size() > 0) void'(fq.pop_front());
      if (fifo_push && fq.size() < DEPTH) fq.push_back(fifo_data_in);
    end
    fifoCount <= fq.size();
    fifoHead  <= (fq.size() > 0) ? fq[0] : '0;
  end

  assign fifo_empty    = (fifoCount == 0) && !forceNotEmpty;
  assign fifo_full     = (fifoCount == DEPTH);
  assign fifo_data_out = fifoHead;

  // Reference model and scoreboard
  logic [WIDTH-1:0] reqData[NREQ] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [WIDTH-1:0] expQ[$];
  int   modelPtr = 0;
  int   modelOcc = 0;
  logic expErr   = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic applyStimulus(input logic [NREQ-1:0] reqV, input logic readyV,
                               input logic rstV);
    logic [NREQ-1:0] expGnt;
    logic expValid, expPop, expFull, expSpace, found;
    int g, k;
    logic [WIDTH-1:0] expData;
    rst           = rstV;
    bus.req       = reqV;
    bus.out_ready = readyV;
    @(negedge clk);
    expValid = forceNotEmpty || (modelOcc > 0);
    expPop   = expValid && readyV;
    expFull  = (modelOcc == DEPTH);
    expSpace = !expFull || expPop;
    expGnt   = '0;
    found    = 1'b0;
    g        = 0;
    if (!rstV && expSpace) begin
      for (int j = 0; j < NREQ; j++) begin
        k = (modelPtr + j) % NREQ;
        if (!found && reqV[k]) begin
          found = 1'b1;
          g     = k;
        end
      end
      if (found) expGnt[g] = 1'b1;
    end
    checkOutput("gnt", 32'(bus.gnt), 32'(expGnt));
    checkOutput("fifo_push", 32'(fifo_push), 32'(found && expGnt != '0));
    checkOutput("fifo_data_in", 32'(fifo_data_in), (expGnt != '0) ? 32'(reqData[g]) : 32'd0);
    checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
    checkOutput("fifo_pop", 32'(fifo_pop), 32'(expPop));
    checkOutput("occupancy", 32'(occupancy), 32'(modelOcc));
    checkOutput("err", 32'(err), 32'(expErr));
    if (expPop && !rstV && !forceNotEmpty) begin
      if (expQ.size() == 0) checkOutput("scoreboard_empty", 32'd1, 32'd0);
      else begin
        expData = expQ.pop_front();
        checkOutput("out_data", 32'(bus.out_data), 32'(expData));
      end
    end
    if (rstV) begin
      modelPtr = 0;
      modelOcc = 0;
      expErr   = 1'b0;
      expQ.delete();
    end else begin
      expErr = expErr | ((modelOcc == 0) != !expValid);
      if (expGnt != '0) begin
        expQ.push_back(reqData[g]);
        modelOcc++;
        modelPtr = (g + 1) % NREQ;
      end
      if (expPop) modelOcc--;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req       = '0;
    bus.out_ready = 1'b0;
    bus.req_data  = {reqData[3], reqData[2], reqData[1], reqData[0]};

    // Reset with requests pending: grants must stay off
    applyStimulus(4'b1111, 1'b0, 1'b1);
    applyStimulus(4'b1111, 1'b0, 1'b1);

    // Fill: grants rotate 0,1,2,3,0,1,2,3, then full blocks everyone
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("occupancy_full", 32'(occupancy), 32'd8);

    // Full FIFO: push and pop in the same cycle
    applyStimulus(4'b0100, 1'b1, 1'b0);
    // ptr=3, only req[1]; then all requesting -> req[2] wins
    applyStimulus(4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0);

    // Drain past empty: no pops on the empty FIFO
    for (int i = 0; i < 10; i++) applyStimulus(4'b0000, 1'b1, 1'b0);

    // Clean refill and drain in push order A,B,C,D,A,B,C,D
    applyStimulus(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(4'b0000, 1'b1, 1'b0);

    // Flag mismatch: empty deasserted while shadow count is zero
    forceNotEmpty = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    forceNotEmpty = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b0, 1'b0);

    // Reset mid-stream with five entries held
    applyStimulus(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(4'b0000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
